// File: rtl/ulpi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ulpi_reg_arbiter
// Description : Shares the single ULPI PHY register-access port among
//               NUM_REQ requesters. Single-cycle request pulses are latched
//               into per-requester slots, granted round-robin, and the
//               granted address/data are held stable for the whole PHY
//               transaction. A timeout aborts transactions on a hung PHY.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               req_en_i/req_we_i  - per-requester request pulse / write sel
//               req_addr_i/req_din_i - packed 8-bit address / write data
//               req_rdy_o/req_err_o  - completion pulse / timed-out flag
//               req_drop_o         - request ignored (already pending)
//               req_dout_o         - read data, valid with req_rdy_o
//               busy_o             - arbiter not idle
//               reg_*              - ULPI PHY register-access port
// Revision    : 1.0 - initial release
// ============================================================================
module ulpi_reg_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_en_i,
  input  logic [NUM_REQ-1:0]   req_we_i,
  input  logic [8*NUM_REQ-1:0] req_addr_i,
  input  logic [8*NUM_REQ-1:0] req_din_i,
  output logic [NUM_REQ-1:0]   req_rdy_o,
  output logic [NUM_REQ-1:0]   req_err_o,
  output logic [NUM_REQ-1:0]   req_drop_o,
  output logic [7:0]           req_dout_o,
  output logic                 busy_o,
  output logic                 reg_en_o,
  output logic                 reg_we_o,
  output logic [7:0]           reg_addr_o,
  output logic [7:0]           reg_din_o,
  input  logic                 reg_rdy_i,
  input  logic [7:0]           reg_dout_i
);

  localparam int                   GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW:0]          NUM_REQ_X = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0]        LAST_IDX  = GW'(NUM_REQ - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          ptr_q, ptr_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic                   err_q, err_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [NUM_REQ-1:0]     pend_q, pend_d;
  logic [NUM_REQ-1:0]     drop_q, drop_d;
  logic [NUM_REQ-1:0]     cap;
  logic                   done_self;

  logic                   slot_we_q   [NUM_REQ];
  logic [7:0]             slot_addr_q [NUM_REQ];
  logic [7:0]             slot_din_q  [NUM_REQ];

  logic                   rr_found;
  logic [GW-1:0]          rr_idx;
  logic [GW:0]            rr_cand;
  logic [NUM_REQ-1:0]     grant_oh;

  // Round-robin search: first pending requester at or after the pointer,
  // wrapping modulo NUM_REQ (works for non-power-of-two NUM_REQ).
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    rr_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_cand = {1'b0, ptr_q} + (GW+1)'(k);
      if (rr_cand >= NUM_REQ_X) rr_cand = rr_cand - NUM_REQ_X;
      if (!rr_found && pend_q[rr_cand[GW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand[GW-1:0];
      end
    end
  end

  // Request capture. In the owner's DONE cycle the pending bit is being
  // cleared, so a fresh pulse there is accepted (set overrides clear).
  always_comb begin
    pend_d    = pend_q;
    drop_d    = '0;
    cap       = '0;
    done_self = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done_self = (state_q == S_DONE) && (grant_q == GW'(i));
      if (done_self) pend_d[i] = 1'b0;
      if (req_en_i[i]) begin
        if (!pend_q[i] || done_self) begin
          cap[i]    = 1'b1;
          pend_d[i] = 1'b1;
        end else begin
          drop_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_we_q[i]   <= 1'b0;
        slot_addr_q[i] <= 8'h00;
        slot_din_q[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap[i]) begin
          slot_we_q[i]   <= req_we_i[i];
          slot_addr_q[i] <= req_addr_i[8*i +: 8];
          slot_din_q[i]  <= req_din_i[8*i +: 8];
        end
      end
    end
  end

  // Next-state logic. The timeout compares the already-incremented count,
  // so the abort happens in the TIMEOUT-th WAIT cycle; reg_rdy in that same
  // cycle still completes the transaction normally.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    tmo_inc = tmo_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_d = rr_idx;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        tmo_d = tmo_inc;
        if (reg_rdy_i) begin
          rdata_d = reg_dout_i;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (tmo_inc == TMO_LIMIT) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  always_comb begin
    busy_o     = (state_q != S_IDLE);
    reg_en_o   = 1'b0;
    reg_we_o   = 1'b0;
    reg_addr_o = 8'h00;
    reg_din_o  = 8'h00;
    req_rdy_o  = '0;
    req_err_o  = '0;
    req_dout_o = 8'h00;
    req_drop_o = drop_q;
    if (state_q == S_ISSUE) begin
      reg_en_o = 1'b1;
      reg_we_o = slot_we_q[grant_q];
    end
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      reg_addr_o = slot_addr_q[grant_q];
      reg_din_o  = slot_din_q[grant_q];
    end
    if (state_q == S_DONE) begin
      req_rdy_o  = grant_oh;
      req_err_o  = err_q ? grant_oh : '0;
      req_dout_o = rdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ulpi_reg_arbiter
// Description : Self-checking bench for ulpi_reg_arbiter. A transaction-level
//               reference model (pending set, slots, round-robin pointer,
//               issue/complete cycle numbers) predicts every output each
//               cycle; directed scenarios are followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ulpi_reg_arbiter;
  localparam int N   = 2;
  localparam int TMO = 255;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_en = '0, req_we = '0;
  logic [8*N-1:0] req_addr = '0, req_din = '0;
  logic [N-1:0]   req_rdy, req_err, req_drop;
  logic [7:0]     req_dout;
  logic           busy, reg_en, reg_we;
  logic [7:0]     reg_addr, reg_din;
  logic           reg_rdy = 1'b0;
  logic [7:0]     reg_dout = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  ulpi_reg_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_en_i(req_en), .req_we_i(req_we), .req_addr_i(req_addr), .req_din_i(req_din),
    .req_rdy_o(req_rdy), .req_err_o(req_err), .req_drop_o(req_drop), .req_dout_o(req_dout),
    .busy_o(busy), .reg_en_o(reg_en), .reg_we_o(reg_we),
    .reg_addr_o(reg_addr), .reg_din_o(reg_din),
    .reg_rdy_i(reg_rdy), .reg_dout_i(reg_dout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state (transaction level).
  bit         m_pend [N];
  bit         m_we   [N];
  bit [7:0]   m_addr [N];
  bit [7:0]   m_din  [N];
  int         m_ptr, m_owner, m_en_cyc, m_done_cyc;
  bit         m_act, m_known, m_err;
  bit [7:0]   m_dout;
  bit [N-1:0] m_drop;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_we[i] = 0; m_addr[i] = 0; m_din[i] = 0;
    end
    m_ptr = 0; m_owner = 0; m_en_cyc = 0; m_done_cyc = 0;
    m_act = 0; m_known = 0; m_err = 0; m_dout = 0; m_drop = '0;
  endtask

  // Check this cycle's outputs, advance the model with this cycle's inputs,
  // then move to the next cycle and return pulse inputs to idle.
  task automatic tick();
    bit         done_now, xfer;
    bit         pend0 [N];
    logic [N-1:0] oh;
    oh       = N'(1) << m_owner;
    done_now = m_act && m_known && (cyc == m_done_cyc);
    xfer     = m_act && (cyc >= m_en_cyc) && !done_now;

    check_val("busy",     busy,     32'(m_act && cyc >= m_en_cyc));
    check_val("reg_en",   reg_en,   32'(m_act && cyc == m_en_cyc));
    check_val("reg_we",   reg_we,   32'(m_act && cyc == m_en_cyc && m_we[m_owner]));
    check_val("reg_addr", reg_addr, xfer ? 32'(m_addr[m_owner]) : 32'h0);
    check_val("reg_din",  reg_din,  xfer ? 32'(m_din[m_owner])  : 32'h0);
    check_val("req_rdy",  req_rdy,  done_now ? 32'(oh) : 32'h0);
    check_val("req_err",  req_err,  (done_now && m_err) ? 32'(oh) : 32'h0);
    check_val("req_drop", req_drop, 32'(m_drop));
    if (done_now) check_val("req_dout", req_dout, 32'(m_dout));

    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) pend0[i] = m_pend[i];
      m_drop = '0;
      if (m_act && !m_known && cyc > m_en_cyc) begin
        if (reg_rdy) begin
          m_known = 1; m_done_cyc = cyc + 1; m_err = 0; m_dout = reg_dout;
        end else if (cyc - m_en_cyc == TMO) begin
          m_known = 1; m_done_cyc = cyc + 1; m_err = 1; m_dout = 8'h00;
        end
      end
      if (!m_act) begin
        for (int k = 0; k < N; k++) begin
          automatic int j = (m_ptr + k) % N;
          if (pend0[j]) begin
            m_act = 1; m_owner = j; m_en_cyc = cyc + 1; m_known = 0;
            break;
          end
        end
      end
      if (done_now) begin
        m_pend[m_owner] = 0;
        m_ptr = (m_owner + 1) % N;
        m_act = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_en[i]) begin
          if (!pend0[i] || (done_now && m_owner == i)) begin
            m_pend[i] = 1; m_we[i] = req_we[i];
            m_addr[i] = req_addr[8*i +: 8]; m_din[i] = req_din[8*i +: 8];
          end else begin
            m_drop[i] = 1;
          end
        end
      end
    end

    @(negedge clk);
    cyc++;
    req_en  = '0;
    reg_rdy = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic req(input int i, input bit we, input bit [7:0] a, input bit [7:0] d);
    req_en[i]         = 1'b1;
    req_we[i]         = we;
    req_addr[8*i +: 8] = a;
    req_din[8*i +: 8]  = d;
  endtask

  task automatic run(input int n, input int rdy_pct);
    for (int c = 0; c < n; c++) begin
      reg_rdy  = ($urandom_range(0, 99) < rdy_pct);
      reg_dout = 8'($urandom);
      tick();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset state
    rst = 1'b1; tick();
    tick();

    // Single write to requester 0
    req(0, 1'b1, 8'h0A, 8'h00); tick();
    repeat (3) tick();
    reg_rdy = 1'b1; reg_dout = 8'h11; tick();
    repeat (3) tick();

    // Read by requester 1
    req(1, 1'b0, 8'h04, 8'h00); tick();
    repeat (3) tick();
    reg_rdy = 1'b1; reg_dout = 8'h45; tick();
    repeat (3) tick();

    // Contention, twice
    req(0, 1'b1, 8'h10, 8'hA0); req(1, 1'b0, 8'h20, 8'hB0); tick();
    run(30, 40);
    req(0, 1'b0, 8'h11, 8'hA1); req(1, 1'b1, 8'h21, 8'hB1); tick();
    tick(); tick();
    req(0, 1'b1, 8'h12, 8'hA2); tick();
    run(40, 40);

    // Duplicate while pending, then re-request in the DONE cycle
    req(0, 1'b1, 8'h30, 8'h31); tick();
    tick();
    req(0, 1'b0, 8'h3F, 8'h3E); tick();
    reg_rdy = 1'b1; reg_dout = 8'h77; tick();
    req(0, 1'b0, 8'h32, 8'h33); tick();
    run(12, 50);

    // Timeout, with a second requester waiting behind it
    req(0, 1'b0, 8'h40, 8'h00); tick();
    tick();
    req(1, 1'b0, 8'h41, 8'h00); tick();
    run(300, 0);
    run(20, 60);

    // reg_rdy in the last WAIT cycle before the timeout wins
    req(1, 1'b0, 8'h50, 8'h00); tick();
    repeat (256) tick();
    reg_rdy = 1'b1; reg_dout = 8'h5A; tick();
    run(6, 0);

    // Reset during WAIT, then a normal request
    req(1, 1'b1, 8'h60, 8'h61); tick();
    repeat (4) tick();
    rst = 1'b1; tick();
    tick(); tick();
    req(0, 1'b1, 8'h62, 8'h63); tick();
    run(15, 50);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 12) req(i, 1'($urandom), 8'($urandom), 8'($urandom));
      reg_rdy  = ($urandom_range(0, 99) < 30);
      reg_dout = 8'($urandom);
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      tick();
    end
    run(20, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
